// File: rtl/tl45_pkg.sv
// tl45_pkg: shared opcode type, register-zero constant and forwarding bus struct
package tl45_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REG_WIDTH = 4;
  typedef logic [4:0] opcode_t;
  localparam logic [REG_WIDTH-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic en;
    logic [REG_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] val;
  } fwd_t;
  function automatic logic fwd_hit(input fwd_t f, input logic [REG_WIDTH-1:0] s);
    return f.en && f.rd == s;
  endfunction
endpackage

// File: rtl/tl45_operand_mux.sv
// tl45_operand_mux: resolves one source operand, youngest forwarding stage first
module tl45_operand_mux
  import tl45_pkg::*;
(
  input  logic [REG_WIDTH-1:0]  src,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  fwd_t                  alu,
  input  fwd_t                  mem,
  input  fwd_t                  wb,
  output logic [DATA_WIDTH-1:0] val
);
  // r0 is hardwired zero; wb bypass covers the same-edge register-file write
  always_comb
    val = src == REG_ZERO ? '0 :
          fwd_hit(alu, src) ? alu.val :
          fwd_hit(mem, src) ? mem.val :
          fwd_hit(wb, src)  ? wb.val  : rf_data;
endmodule

// File: rtl/tl45_register_read.sv
// tl45_register_read: operand fetch with forwarding, load-use stall and flush; TL45_RR_PERF_EN enables the hazard stall counter
module tl45_register_read
  import tl45_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int REG_W  = REG_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  opcode_t           i_opcode,
  input  logic [REG_W-1:0]  i_dr,
  input  logic [REG_W-1:0]  i_sr1,
  input  logic [REG_W-1:0]  i_sr2,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_pc,
  output logic [REG_W-1:0]  o_rf_addr1,
  output logic [REG_W-1:0]  o_rf_addr2,
  input  logic [DATA_W-1:0] i_rf_data1,
  input  logic [DATA_W-1:0] i_rf_data2,
  input  logic              i_alu_fwd_en,
  input  logic [REG_W-1:0]  i_alu_fwd_reg,
  input  logic [DATA_W-1:0] i_alu_fwd_val,
  input  logic              i_alu_pending,
  input  logic              i_mem_fwd_en,
  input  logic [REG_W-1:0]  i_mem_fwd_reg,
  input  logic [DATA_W-1:0] i_mem_fwd_val,
  input  logic              i_wb_en,
  input  logic [REG_W-1:0]  i_wb_reg,
  input  logic [DATA_W-1:0] i_wb_val,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output opcode_t           o_opcode,
  output logic [REG_W-1:0]  o_dr,
  output logic [DATA_W-1:0] o_val1,
  output logic [DATA_W-1:0] o_val2,
  output logic [DATA_W-1:0] o_imm,
  output logic [DATA_W-1:0] o_pc,
  output logic [31:0]       o_stall_cnt
);
  fwd_t alu_f, mem_f, wb_f;
  logic [DATA_W-1:0] val1, val2;
  logic hazard, advance, accept;
  assign o_rf_addr1 = i_sr1;
  assign o_rf_addr2 = i_sr2;
  assign alu_f = '{en: i_alu_fwd_en, rd: i_alu_fwd_reg, val: i_alu_fwd_val};
  assign mem_f = '{en: i_mem_fwd_en, rd: i_mem_fwd_reg, val: i_mem_fwd_val};
  assign wb_f  = '{en: i_wb_en, rd: i_wb_reg, val: i_wb_val};
  tl45_operand_mux u_mux1 (.src(i_sr1), .rf_data(i_rf_data1), .alu(alu_f), .mem(mem_f), .wb(wb_f), .val(val1));
  tl45_operand_mux u_mux2 (.src(i_sr2), .rf_data(i_rf_data2), .alu(alu_f), .mem(mem_f), .wb(wb_f), .val(val2));
  // a pending load in execute cannot be forwarded yet, so its consumers must wait
  always_comb begin
    hazard  = i_valid && i_alu_pending && i_alu_fwd_reg != REG_ZERO &&
              (i_alu_fwd_reg == i_sr1 || i_alu_fwd_reg == i_sr2);
    advance = !o_valid || i_ready;
    o_ready = i_flush || (advance && !hazard);
    accept  = i_valid && o_ready && !i_flush;
  end
  // execute pipeline register: flush, then load, then bubble, else hold
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      o_valid  <= 1'b0;
      o_opcode <= '0;
      o_dr     <= '0;
      o_val1   <= '0;
      o_val2   <= '0;
      o_imm    <= '0;
      o_pc     <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid  <= 1'b1;
      o_opcode <= i_opcode;
      o_dr     <= i_dr;
      o_val1   <= val1;
      o_val2   <= val2;
      o_imm    <= i_imm;
      o_pc     <= i_pc;
    end else if (advance) begin
      o_valid <= 1'b0;
    end
`ifdef TL45_RR_PERF_EN
  // saturating count of cycles lost to load-use stalls
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) o_stall_cnt <= '0;
    else if (hazard && !i_flush && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 32'd1;
`else
  assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_tl45_register_read.sv
// tb_tl45_register_read: directed scoreboard bench for tl45_register_read
module tb_tl45_register_read;
  import tl45_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  logic i_valid, o_ready, i_alu_fwd_en, i_alu_pending, i_mem_fwd_en, i_wb_en, i_flush, o_valid, i_ready;
  opcode_t i_opcode, o_opcode;
  logic [3:0] i_dr, i_sr1, i_sr2, o_rf_addr1, o_rf_addr2, i_alu_fwd_reg, i_mem_fwd_reg, i_wb_reg, o_dr;
  logic [31:0] i_imm, i_pc, i_rf_data1, i_rf_data2, i_alu_fwd_val, i_mem_fwd_val, i_wb_val;
  logic [31:0] o_val1, o_val2, o_imm, o_pc, o_stall_cnt;
  typedef struct {logic [4:0] op; logic [3:0] dr; logic [31:0] v1, v2, imm, pc;} exp_t;
  exp_t q[$];
  exp_t last;
  int n_chk = 0, n_fail = 0;
`ifdef TL45_RR_PERF_EN
  localparam logic [31:0] STALL1 = 32'd1;
`else
  localparam logic [31:0] STALL1 = 32'd0;
`endif
  always #5 clk = ~clk;
  tl45_register_read dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready), .i_opcode(i_opcode),
    .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2), .i_imm(i_imm), .i_pc(i_pc),
    .o_rf_addr1(o_rf_addr1), .o_rf_addr2(o_rf_addr2), .i_rf_data1(i_rf_data1), .i_rf_data2(i_rf_data2),
    .i_alu_fwd_en(i_alu_fwd_en), .i_alu_fwd_reg(i_alu_fwd_reg), .i_alu_fwd_val(i_alu_fwd_val),
    .i_alu_pending(i_alu_pending), .i_mem_fwd_en(i_mem_fwd_en), .i_mem_fwd_reg(i_mem_fwd_reg),
    .i_mem_fwd_val(i_mem_fwd_val), .i_wb_en(i_wb_en), .i_wb_reg(i_wb_reg), .i_wb_val(i_wb_val),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_opcode(o_opcode), .o_dr(o_dr),
    .o_val1(o_val1), .o_val2(o_val2), .o_imm(o_imm), .o_pc(o_pc), .o_stall_cnt(o_stall_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    i_valid = 0; i_opcode = '0; i_dr = 0; i_sr1 = 0; i_sr2 = 0; i_imm = 0; i_pc = 0;
    i_rf_data1 = 0; i_rf_data2 = 0; i_alu_fwd_en = 0; i_alu_fwd_reg = 0; i_alu_fwd_val = 0;
    i_alu_pending = 0; i_mem_fwd_en = 0; i_mem_fwd_reg = 0; i_mem_fwd_val = 0;
    i_wb_en = 0; i_wb_reg = 0; i_wb_val = 0; i_flush = 0;
  endtask
  task automatic put(input logic [4:0] op, input logic [3:0] dr, s1, s2, input logic [31:0] imm, pc);
    i_valid = 1; i_opcode = op; i_dr = dr; i_sr1 = s1; i_sr2 = s2; i_imm = imm; i_pc = pc;
  endtask
  task automatic push(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] v1, v2, imm, pc);
    exp_t e;
    e.op = op; e.dr = dr; e.v1 = v1; e.v2 = v2; e.imm = imm; e.pc = pc;
    q.push_back(e);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv();
    @(negedge clk);
  endtask
  task automatic match(input string tag, input exp_t e);
    chk({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, ".op"}, {27'd0, o_opcode}, {27'd0, e.op});
    chk({tag, ".dr"}, {28'd0, o_dr}, {28'd0, e.dr});
    chk({tag, ".val1"}, o_val1, e.v1);
    chk({tag, ".val2"}, o_val2, e.v2);
    chk({tag, ".imm"}, o_imm, e.imm);
    chk({tag, ".pc"}, o_pc, e.pc);
  endtask
  task automatic pop_check(input string tag);
    chk({tag, ".sb_nonempty"}, {31'd0, q.size() != 0}, 32'd1);
    if (q.size() != 0) begin
      last = q.pop_front();
      match(tag, last);
    end
  endtask
  initial begin
    idle();
    i_ready = 1;
    #3;
    chk("reset.valid", {31'd0, o_valid}, 32'd0);
    chk("reset.val1", o_val1, 32'd0);
    chk("reset.pc", o_pc, 32'd0);
    chk("reset.stall_cnt", o_stall_cnt, 32'd0);
    drv(); drv();
    reset_n = 1;
    // plain register-file read; sr2=0 must read zero despite junk on rf_data2
    drv();
    put(5'd1, 4'd2, 4'd3, 4'd0, 32'h100, 32'h40);
    i_rf_data1 = 32'h11; i_rf_data2 = 32'h99;
    #1;
    chk("plain.rf_addr1", {28'd0, o_rf_addr1}, 32'd3);
    chk("plain.ready", {31'd0, o_ready}, 32'd1);
    push(5'd1, 4'd2, 32'h11, 32'h0, 32'h100, 32'h40);
    step(); pop_check("plain");
    // forwarding priority ALU > MEM > WB > register file
    drv();
    put(5'd2, 4'd6, 4'd5, 4'd5, 32'h1, 32'h44);
    i_rf_data1 = 32'h77; i_rf_data2 = 32'h77;
    i_alu_fwd_en = 1; i_alu_fwd_reg = 5; i_alu_fwd_val = 32'hAA;
    i_mem_fwd_en = 1; i_mem_fwd_reg = 5; i_mem_fwd_val = 32'hBB;
    i_wb_en = 1; i_wb_reg = 5; i_wb_val = 32'hCC;
    push(5'd2, 4'd6, 32'hAA, 32'hAA, 32'h1, 32'h44);
    step(); pop_check("fwd_alu");
    drv();
    i_alu_fwd_en = 0; i_pc = 32'h48;
    push(5'd2, 4'd6, 32'hBB, 32'hBB, 32'h1, 32'h48);
    step(); pop_check("fwd_mem");
    drv();
    i_mem_fwd_en = 0; i_pc = 32'h4C;
    push(5'd2, 4'd6, 32'hCC, 32'hCC, 32'h1, 32'h4C);
    step(); pop_check("fwd_wb");
    // pending load on r0 never hazards
    drv(); idle();
    put(5'd3, 4'd1, 4'd0, 4'd0, 32'h2, 32'h50);
    i_alu_pending = 1; i_alu_fwd_reg = 0;
    #1;
    chk("r0_nohaz.ready", {31'd0, o_ready}, 32'd1);
    push(5'd3, 4'd1, 32'h0, 32'h0, 32'h2, 32'h50);
    step(); pop_check("r0_nohaz");
    // load-use hazard on sr2 inserts a bubble
    drv(); idle();
    put(5'd4, 4'd8, 4'd1, 4'd7, 32'h3, 32'h54);
    i_rf_data1 = 32'h21;
    i_alu_pending = 1; i_alu_fwd_reg = 7;
    #1;
    chk("hazard.ready", {31'd0, o_ready}, 32'd0);
    step();
    chk("hazard.bubble", {31'd0, o_valid}, 32'd0);
    chk("hazard.stall_cnt", o_stall_cnt, STALL1);
    drv();
    i_alu_pending = 0; i_mem_fwd_en = 1; i_mem_fwd_reg = 7; i_mem_fwd_val = 32'h55;
    #1;
    chk("hazard_clr.ready", {31'd0, o_ready}, 32'd1);
    push(5'd4, 4'd8, 32'h21, 32'h55, 32'h3, 32'h54);
    step(); pop_check("hazard_clr");
    chk("hazard_clr.stall_cnt", o_stall_cnt, STALL1);
    // backpressure holds outputs and ignores later register-file changes
    drv(); idle();
    put(5'd5, 4'd9, 4'd2, 4'd3, 32'h4, 32'h58);
    i_rf_data1 = 32'h31; i_rf_data2 = 32'h32;
    push(5'd5, 4'd9, 32'h31, 32'h32, 32'h4, 32'h58);
    step(); pop_check("bp_a");
    drv();
    i_ready = 0;
    put(5'd6, 4'd10, 4'd2, 4'd3, 32'h5, 32'h5C);
    i_rf_data1 = 32'h41; i_rf_data2 = 32'h42;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp.ready", {31'd0, o_ready}, 32'd0);
      step();
      match("bp.hold", last);
      drv();
    end
    i_ready = 1;
    #1;
    chk("bp_rel.ready", {31'd0, o_ready}, 32'd1);
    push(5'd6, 4'd10, 32'h41, 32'h42, 32'h5, 32'h5C);
    step(); pop_check("bp_b");
    // flush wins over a valid input, even one that would hazard
    drv();
    put(5'd7, 4'd11, 4'd7, 4'd7, 32'h6, 32'h60);
    i_alu_pending = 1; i_alu_fwd_reg = 7;
    i_flush = 1;
    #1;
    chk("flush.ready", {31'd0, o_ready}, 32'd1);
    step();
    chk("flush.valid", {31'd0, o_valid}, 32'd0);
    chk("flush.pc_not_loaded", o_pc, 32'h5C);
    chk("flush.stall_cnt", o_stall_cnt, STALL1);
    // asynchronous reset between edges drops the held instruction at once
    drv(); idle();
    put(5'd8, 4'd12, 4'd0, 4'd0, 32'h7, 32'h64);
    push(5'd8, 4'd12, 32'h0, 32'h0, 32'h7, 32'h64);
    step(); pop_check("pre_reset");
    i_valid = 0;
    #2;
    reset_n = 0;
    #1;
    chk("async_reset.valid", {31'd0, o_valid}, 32'd0);
    chk("async_reset.pc", o_pc, 32'd0);
    chk("async_reset.stall_cnt", o_stall_cnt, 32'd0);
    drv();
    reset_n = 1;
    step();
    chk("post_reset.valid", {31'd0, o_valid}, 32'd0);
    chk("sb_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tl45_register_read.md
Name: tl45_register_read

Overview:
- Operand-fetch stage between decode and the ALU/execute stage.
- Accepts one decoded instruction per cycle and drives the two combinational register-file read addresses.
- Resolves each source value by forwarding from ALU, MEM and WB, and registers the resolved operands into the execute pipeline register.
- Stalls decode on a load-use hazard and drops in-flight work on a branch flush.

Parameters:
- DATA_W, 32, operand/data width
- REG_W, 4, register address width; register 0 reads as constant 0

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  decode has an instruction
- o_ready  out  1  stage accepts input this cycle
- i_opcode  in  5  decoded opcode
- i_dr  in  REG_W  destination register
- i_sr1  in  REG_W  source register 1
- i_sr2  in  REG_W  source register 2
- i_imm  in  DATA_W  immediate
- i_pc  in  DATA_W  instruction PC
- o_rf_addr1  out  REG_W  register-file read address 1 (= i_sr1, combinational)
- o_rf_addr2  out  REG_W  register-file read address 2 (= i_sr2, combinational)
- i_rf_data1  in  DATA_W  register-file read data 1 (same cycle)
- i_rf_data2  in  DATA_W  register-file read data 2 (same cycle)
- i_alu_fwd_en  in  1  execute-stage result valid
- i_alu_fwd_reg  in  REG_W  execute-stage destination
- i_alu_fwd_val  in  DATA_W  execute-stage result
- i_alu_pending  in  1  execute-stage instruction is a load; its result is not yet available
- i_mem_fwd_en  in  1  memory-stage result valid
- i_mem_fwd_reg  in  REG_W  memory-stage destination
- i_mem_fwd_val  in  DATA_W  memory-stage result
- i_wb_en  in  1  writeback write enable (same signals as the register-file write)
- i_wb_reg  in  REG_W  writeback register
- i_wb_val  in  DATA_W  writeback value
- i_flush  in  1  branch flush
- o_valid  out  1  execute register holds an instruction
- i_ready  in  1  execute stage accepts
- o_opcode  out  5  registered opcode
- o_dr  out  REG_W  registered destination register
- o_val1  out  DATA_W  resolved operand 1
- o_val2  out  DATA_W  resolved operand 2
- o_imm  out  DATA_W  registered immediate
- o_pc  out  DATA_W  registered PC
- o_stall_cnt  out  32  hazard stall counter (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): all registered outputs are 0, including o_valid and o_stall_cnt.
- Latency: one cycle. An input accepted at edge N appears on the outputs after edge N.
- Operand resolution, per source s (combinational):
  - s==0 gives 0, with no forwarding.
  - Otherwise priority is ALU (en && reg==s) > MEM > WB > i_rf_dataX.
  - WB bypass is mandatory, because the register-file write lands at the same edge as the read.
- Hazard:
  - hazard = i_valid && i_alu_pending && i_alu_fwd_reg!=0 && (i_alu_fwd_reg==i_sr1 || i_alu_fwd_reg==i_sr2).
  - A source equal to 0 never hazards.
- Handshake:
  - advance = !o_valid || i_ready.
  - o_ready = i_flush || (advance && !hazard).
  - Accept = i_valid && o_ready && !i_flush.
- Output register update:
  - On flush: o_valid<=0 and the input is discarded. Flush has priority over all other events.
  - Else on Accept: load all output fields and set o_valid<=1.
  - Else if advance: o_valid<=0 (bubble inserted on hazard or idle). Data fields may hold their previous values.
  - Else (downstream stalled): hold all outputs.
- Stability: while o_valid && !i_ready, all outputs stay stable. Forwarded values are captured at accept and are never re-resolved afterwards.
- Simultaneous ALU and MEM forwarding of the same register: the ALU value wins (it is younger).
- Reset mid-transaction: the instruction in the stage is lost; o_valid=0 on the first edge after release.

Optional Feature:
- Macro: TL45_RR_PERF_EN.
- Defined: o_stall_cnt increments by 1 on every cycle with hazard && !i_flush. It saturates at 32'hFFFFFFFF and is cleared only by reset.
- Undefined: o_stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package tl45_pkg:
  - opcode typedef (5 bits)
  - REG_ZERO constant
  - packed struct fwd_t {en, reg, val} used for the ALU/MEM/WB forwarding buses
- Sub-module tl45_operand_mux (instantiated twice, once per source):
  - inputs: source register, register-file data, three fwd_t
  - output: resolved value

Test Plan:
- Plain read: r3=0x11 in the register file, sr1=3, sr2=0, no forwarding → next cycle o_val1=0x11, o_val2=0, o_valid=1.
- Forward priority: ALU r5=0xAA, MEM r5=0xBB, WB r5=0xCC, sr1=sr2=5 → o_val1=o_val2=0xAA. Remove ALU → 0xBB. Remove MEM → 0xCC.
- Load-use: i_alu_pending=1, i_alu_fwd_reg=7, sr2=7 → o_ready=0, bubble (o_valid=0), o_stall_cnt=1 with PERF_EN. Drop pending, MEM supplies 0x55 → accepted, o_val2=0x55.
- Backpressure: i_ready=0 for 3 cycles with o_valid=1 → outputs unchanged and o_ready=0. Raise i_ready → the next instruction loads.
- Flush: i_flush=1 together with i_valid=1 → o_ready=1, o_valid=0 next cycle, nothing is loaded.
- Async reset: assert reset_n=0 between clock edges with o_valid=1 → o_valid drops immediately, before the next edge.
